cpu_trace_monitor: RTL and testbench

Synthesizable observation block that sits beside the multi-cycle processor `top` in the simulation and FPGA-debug harness and turns its debug ports into a checked, buffered trace. It counts cycles and retired instructions and captures every architectural write (register, long-multiply high word, memory) into a parametrised FIFO. It detects program end (branch-to-self) or timeout, and streams records out over a valid/ready port, so benches no longer rely on waveform inspection.

---
 rtl/cpu_trace_pkg.sv | 30 +++
 rtl/trace_fifo.sv | 46 ++++
 rtl/cpu_trace_monitor.sv | 175 +++++++++++++++++
 tb/tb_cpu_trace_monitor.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared encodings for the processor trace monitor: record kinds, control states and record layout.
// A trace record is {trace_hdr_t, cycle stamp}; the stamp width follows the monitor's counter width.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    KIND_REG   = 2'd0,
    KIND_MEM   = 2'd1,
    KIND_REGHI = 2'd2
  } trace_kind_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } ctrl_state_t;

  localparam logic [3:0] FETCH_DEFAULT = 4'd0;
  localparam int HDR_W = 2 + 4 + 32 + 32;

  typedef struct packed {
    trace_kind_t kind;
    logic [3:0]  idx;
    logic [31:0] data;
    logic [31:0] addr;
  } trace_hdr_t;

  function automatic int rec_width(input int cnt_w);
    return HDR_W + cnt_w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic DEPTH x W first-word-fall-through FIFO, head word visible with zero latency while not empty.
// A push into a full FIFO is refused unless a pop happens in the same cycle; reads of an empty FIFO return 0.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/cpu_trace_monitor.sv
// Counts cycles/instructions, detects halt or timeout, and captures architectural writes into a trace FIFO.
// Capture in cycle N is visible on tr_* in N+1 (REGHI at N+2); records are held stable until tr_ready, dropped with overflow when full.
module cpu_trace_monitor
  import cpu_trace_pkg::*;
#(
  parameter int         DEPTH       = 16,
  parameter int         CNT_W       = 32,
  parameter int         MAX_CYCLES  = 10000,
  parameter int         HALT_REPEAT = 3,
  parameter logic [3:0] FETCH_STATE = FETCH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       state,
  input  logic [31:0]      PC,
  input  logic             RegWrite,
  input  logic [3:0]       Rd,
  input  logic [31:0]      Result,
  input  logic             IsLongMul,
  input  logic [3:0]       Ra,
  input  logic [31:0]      ALUResult2,
  input  logic             MemWrite,
  input  logic [31:0]      Adr,
  input  logic [31:0]      WriteData,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  output logic             overflow,
  output logic             tr_valid,
  input  logic             tr_ready,
  output logic [1:0]       tr_kind,
  output logic [3:0]       tr_idx,
  output logic [31:0]      tr_data,
  output logic [31:0]      tr_addr,
  output logic [CNT_W-1:0] tr_cycle
);
  localparam int REC_W = rec_width(CNT_W);
  localparam int REP_W = $clog2(HALT_REPEAT + 1);
  localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);
  localparam logic [REP_W-1:0] REP_MAX    = REP_W'(HALT_REPEAT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

  ctrl_state_t      st, st_nxt;
  logic             run, fetch, halt_hit, timeout_hit, finish, advance;
  logic [31:0]      last_pc;
  logic             seen_fetch;
  logic [REP_W-1:0] rep, rep_nxt;

  logic             cap_reg, cap_mem, cap_hi;
  trace_hdr_t       reg_hdr, mem_hdr, hi_hdr, head_hdr;
  logic [REC_W-1:0] pend_rec, pend_rec_nxt, push_rec, head_rec;
  logic             pend_vld, pend_vld_nxt, push, pop, drop;
  logic             fifo_full, fifo_empty;

  assign run   = (st == ST_RUN);
  assign fetch = run && (state == FETCH_STATE);

  always_comb begin
    rep_nxt = rep;
    if (fetch) rep_nxt = (seen_fetch && (PC == last_pc)) ? rep + REP_ONE : REP_ONE;
  end

  assign halt_hit    = fetch && (rep_nxt == REP_MAX);
  assign timeout_hit = run && (cycle_cnt == LAST_CYCLE);
  assign finish      = halt_hit || timeout_hit;
  // The terminating cycle itself is not counted, so the counters freeze at their final values.
  assign advance     = run && !finish;

  always_comb begin
    st_nxt = st;
    case (st)
      ST_RUN:  if (finish) st_nxt = ST_DONE;
      ST_DONE: st_nxt = ST_DONE;
      default: st_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= ST_RUN;
    else        st <= st_nxt;
  end

  assign done = (st == ST_DONE);

  assign cap_reg = run && RegWrite;
  assign cap_mem = run && MemWrite;
  assign cap_hi  = cap_reg && IsLongMul;
  assign reg_hdr = '{kind: KIND_REG,   idx: Rd,   data: Result,     addr: 32'd0};
  assign mem_hdr = '{kind: KIND_MEM,   idx: 4'd0, data: WriteData,  addr: Adr};
  assign hi_hdr  = '{kind: KIND_REGHI, idx: Ra,   data: ALUResult2, addr: 32'd0};

  // One push per cycle: a waiting pending record always goes first and blocks any new event.
  always_comb begin
    push         = 1'b0;
    push_rec     = '0;
    drop         = 1'b0;
    pend_vld_nxt = pend_vld;
    pend_rec_nxt = pend_rec;
    if (pend_vld) begin
      push         = 1'b1;
      push_rec     = pend_rec;
      pend_vld_nxt = 1'b0;
      drop         = cap_reg || cap_mem;
    end else if (cap_reg) begin
      push     = 1'b1;
      push_rec = {reg_hdr, cycle_cnt};
      if (cap_mem) begin
        pend_vld_nxt = 1'b1;
        pend_rec_nxt = {mem_hdr, cycle_cnt};
        drop         = cap_hi;
      end else if (cap_hi) begin
        pend_vld_nxt = 1'b1;
        pend_rec_nxt = {hi_hdr, cycle_cnt};
      end
    end else if (cap_mem) begin
      push     = 1'b1;
      push_rec = {mem_hdr, cycle_cnt};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
      overflow   <= 1'b0;
      last_pc    <= '0;
      seen_fetch <= 1'b0;
      rep        <= '0;
      pend_vld   <= 1'b0;
      pend_rec   <= '0;
    end else begin
      if (advance) cycle_cnt <= cycle_cnt + CNT_ONE;
      if (advance && fetch && seen_fetch) instr_cnt <= instr_cnt + CNT_ONE;
      if (fetch) begin
        last_pc    <= PC;
        seen_fetch <= 1'b1;
        rep        <= rep_nxt;
      end
      if (halt_hit)    halted  <= 1'b1;
      if (timeout_hit) timeout <= 1'b1;
      if (drop || (push && fifo_full && !pop)) overflow <= 1'b1;
      pend_vld <= pend_vld_nxt;
      pend_rec <= pend_rec_nxt;
    end
  end

  assign tr_valid = !fifo_empty;
  assign pop      = tr_valid && tr_ready;

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (push),
    .push_dat (push_rec),
    .pop      (pop),
    .pop_dat  (head_rec),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign {head_hdr, tr_cycle} = head_rec;
  assign tr_kind = head_hdr.kind;
  assign tr_idx  = head_hdr.idx;
  assign tr_data = head_hdr.data;
  assign tr_addr = head_hdr.addr;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Bench for cpu_trace_monitor: directed vector table, multi-cycle corner sequences, and randomized
// stimulus against a queue-based reference model of the trace rules.
module tb_cpu_trace_monitor;
  localparam int DEPTH = 16;
  localparam int MAXC  = 50;
  localparam int HREP  = 3;
  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] IDLE_ST = 4'd1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  state;
  logic [31:0] PC;
  logic        RegWrite;
  logic [3:0]  Rd;
  logic [31:0] Result;
  logic        IsLongMul;
  logic [3:0]  Ra;
  logic [31:0] ALUResult2;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic        tr_ready;
  logic [31:0] cycle_cnt, instr_cnt;
  logic        done, halted, timeout, overflow, tr_valid;
  logic [1:0]  tr_kind;
  logic [3:0]  tr_idx;
  logic [31:0] tr_data, tr_addr, tr_cycle;

  int n_cmp = 0;
  int n_fail = 0;

  cpu_trace_monitor #(
    .DEPTH(DEPTH), .CNT_W(32), .MAX_CYCLES(MAXC), .HALT_REPEAT(HREP), .FETCH_STATE(FETCH)
  ) dut (
    .clk(clk), .reset(reset), .state(state), .PC(PC), .RegWrite(RegWrite), .Rd(Rd),
    .Result(Result), .IsLongMul(IsLongMul), .Ra(Ra), .ALUResult2(ALUResult2),
    .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .done(done), .halted(halted),
    .timeout(timeout), .overflow(overflow), .tr_valid(tr_valid), .tr_ready(tr_ready),
    .tr_kind(tr_kind), .tr_idx(tr_idx), .tr_data(tr_data), .tr_addr(tr_addr), .tr_cycle(tr_cycle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rw; logic [3:0] rd; logic [31:0] res; logic lm; logic [3:0] ra; logic [31:0] hi;
    logic mw; logic [31:0] adr; logic [31:0] wd; logic rdy;
    logic ev; logic [1:0] ek; logic [3:0] ei; logic [31:0] ed; logic [31:0] ea; logic [31:0] ec;
  } vec_t;
  vec_t tbl[17];

  typedef struct {
    logic [1:0] kind; logic [3:0] idx; logic [31:0] data; logic [31:0] addr; logic [31:0] cyc;
  } mrec_t;

  int          m_cyc, m_instr, m_nfetch, m_runlen;
  logic [31:0] m_last_pc;
  bit          m_done, m_halted, m_timeout, m_ovf;
  mrec_t       q[$];
  mrec_t       pend[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rec(input string name, input logic v, input logic [1:0] k, input logic [3:0] i,
                         input logic [31:0] d, input logic [31:0] a, input logic [31:0] c);
    chk({name, "_valid"}, tr_valid, v);
    chk({name, "_rec"}, {tr_kind, tr_idx, tr_data, tr_addr, tr_cycle}, {k, i, d, a, c});
  endtask

  task automatic chk_flags(input string name, input logic d, input logic h, input logic t, input logic o);
    chk(name, {done, halted, timeout, overflow}, {d, h, t, o});
  endtask

  task automatic set_idle();
    state = IDLE_ST; PC = 32'h0; RegWrite = 1'b0; Rd = 4'd0; Result = 32'h0;
    IsLongMul = 1'b0; Ra = 4'd0; ALUResult2 = 32'h0; MemWrite = 1'b0; Adr = 32'h0;
    WriteData = 32'h0; tr_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_idle();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic model_reset();
    m_cyc = 0; m_instr = 0; m_nfetch = 0; m_runlen = 0; m_last_pc = 32'h0;
    m_done = 0; m_halted = 0; m_timeout = 0; m_ovf = 0;
    q.delete(); pend.delete();
  endtask

  // One rising edge of the reference: events are listed in priority order REG, MEM, REGHI.
  task automatic model_step();
    bit    run, fetch, hh, ht, push, pop;
    mrec_t ev[$];
    mrec_t pr;
    run   = !m_done;
    fetch = run && (state == FETCH);
    hh = 0; ht = 0; push = 0;
    pr = '{2'd0, 4'd0, 32'd0, 32'd0, 32'd0};
    if (fetch) begin
      if (m_nfetch > 0 && PC == m_last_pc) m_runlen++; else m_runlen = 1;
      m_last_pc = PC;
      hh = (m_runlen >= HREP);
    end
    ht = run && (m_cyc == MAXC - 1);
    if (run && RegWrite) ev.push_back('{2'd0, Rd, Result, 32'd0, 32'(m_cyc)});
    if (run && MemWrite) ev.push_back('{2'd1, 4'd0, WriteData, Adr, 32'(m_cyc)});
    if (run && RegWrite && IsLongMul) ev.push_back('{2'd2, Ra, ALUResult2, 32'd0, 32'(m_cyc)});
    if (pend.size() > 0) begin
      pr = pend.pop_front(); push = 1;
      if (ev.size() > 0) m_ovf = 1;
    end else if (ev.size() > 0) begin
      pr = ev[0]; push = 1;
      if (ev.size() > 1) pend.push_back(ev[1]);
      if (ev.size() > 2) m_ovf = 1;
    end
    pop = tr_ready && (q.size() > 0);
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(pr); else m_ovf = 1;
    end
    if (run && !(hh || ht)) begin
      m_cyc++;
      if (fetch && m_nfetch > 0) m_instr++;
    end
    if (fetch) m_nfetch++;
    if (hh) m_halted = 1;
    if (ht) m_timeout = 1;
    if (hh || ht) m_done = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mrec_t er;
    set_idle();
    for (int i = 0; i < 17; i++) tbl[i] = '{0,0,0,0,0,0,0,0,0,(i==6||i==10||i==13||i==16),0,0,0,0,0,0};
    tbl[5]  = '{1,4'd3,32'hAA,0,0,0,0,0,0,0,  1,2'd0,4'd3,32'hAA,32'h0,32'd5};
    tbl[7]  = '{1,4'd2,32'h1,1,4'd4,32'hFFFF_FFFF,0,0,0,0,  1,2'd0,4'd2,32'h1,32'h0,32'd7};
    tbl[8]  = '{0,0,0,0,0,0,0,0,0,0,  1,2'd0,4'd2,32'h1,32'h0,32'd7};
    tbl[9]  = '{0,0,0,0,0,0,0,0,0,1,  1,2'd2,4'd4,32'hFFFF_FFFF,32'h0,32'd7};
    tbl[11] = '{1,4'd5,32'h55,0,0,0,1,32'h100,32'h77,0,  1,2'd0,4'd5,32'h55,32'h0,32'd11};
    tbl[12] = '{0,0,0,0,0,0,0,0,0,1,  1,2'd1,4'd0,32'h77,32'h100,32'd11};
    tbl[14] = '{0,0,0,0,0,0,1,32'h200,32'h9,1,  1,2'd1,4'd0,32'h9,32'h200,32'd14};
    tbl[15] = '{0,0,0,0,0,0,0,0,0,0,  1,2'd1,4'd0,32'h9,32'h200,32'd14};

    // Reset state while held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cycle", cycle_cnt, 0);
    chk("rst_instr", instr_cnt, 0);
    chk_flags("rst_flags", 0, 0, 0, 0);
    chk_rec("rst", 0, 2'd0, 4'd0, 32'h0, 32'h0, 32'h0);

    // Vector table: capture, long multiply, REG+MEM ordering, handshake.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_idle();
      RegWrite = tbl[i].rw; Rd = tbl[i].rd; Result = tbl[i].res; IsLongMul = tbl[i].lm;
      Ra = tbl[i].ra; ALUResult2 = tbl[i].hi; MemWrite = tbl[i].mw; Adr = tbl[i].adr;
      WriteData = tbl[i].wd; tr_ready = tbl[i].rdy;
      tick();
      chk_rec($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ek, tbl[i].ei, tbl[i].ed, tbl[i].ea, tbl[i].ec);
      chk($sformatf("tbl%0d_cycle", i), cycle_cnt, 32'(i + 1));
      chk($sformatf("tbl%0d_instr", i), instr_cnt, 0);
      chk_flags($sformatf("tbl%0d_flags", i), 0, 0, 0, 0);
    end

    // FIFO overflow: 20 MEM writes, nothing read, then drain in order.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_idle();
      MemWrite = 1'b1; Adr = 32'(i * 4); WriteData = 32'h1000 + 32'(i);
      tick();
      if (i == 15) chk_flags("ovf_at16", 0, 0, 0, 0);
    end
    set_idle();
    chk_flags("ovf_flag", 0, 0, 0, 1);
    for (int j = 0; j < 16; j++) begin
      chk_rec($sformatf("ovf_drain%0d", j), 1, 2'd1, 4'd0, 32'h1000 + 32'(j), 32'(j * 4), 32'(j));
      tr_ready = 1'b1;
      tick();
    end
    chk_rec("ovf_empty", 0, 2'd0, 4'd0, 32'h0, 32'h0, 32'h0);
    chk_flags("ovf_sticky", 0, 0, 0, 1);

    // Halt on three fetches of the same PC; later writes ignored.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      set_idle();
      state = (c == 1 || c == 3 || c == 5 || c == 8) ? FETCH : 4'd2;
      PC = 32'h40;
      if (c == 7) begin RegWrite = 1'b1; Rd = 4'd1; Result = 32'h11; end
      tick();
      if (c == 3) begin
        chk_flags("halt_pre", 0, 0, 0, 0);
        chk("halt_pre_instr", instr_cnt, 1);
        chk("halt_pre_cycle", cycle_cnt, 4);
      end
      if (c == 5) begin
        chk_flags("halt_flags", 1, 1, 0, 0);
        chk("halt_instr", instr_cnt, 1);
        chk("halt_cycle", cycle_cnt, 5);
      end
    end
    chk("halt_nocap", tr_valid, 0);
    chk("halt_frozen_instr", instr_cnt, 1);
    chk("halt_frozen_cycle", cycle_cnt, 5);

    // Timeout, capture in the timeout cycle, pending drain in DONE, async reset mid-drain.
    do_reset();
    for (int c = 0; c < MAXC - 1; c++) tick();
    chk("to_pre_cycle", cycle_cnt, 49);
    chk_flags("to_pre_flags", 0, 0, 0, 0);
    RegWrite = 1'b1; Rd = 4'd7; Result = 32'hC0; MemWrite = 1'b1; Adr = 32'h300; WriteData = 32'hD0;
    tick();
    set_idle();
    chk_flags("to_flags", 1, 0, 1, 0);
    chk("to_cycle", cycle_cnt, 49);
    chk_rec("to_reg", 1, 2'd0, 4'd7, 32'hC0, 32'h0, 32'd49);
    tick();
    chk_rec("to_reg_held", 1, 2'd0, 4'd7, 32'hC0, 32'h0, 32'd49);
    tr_ready = 1'b1;
    tick();
    chk_rec("to_mem", 1, 2'd1, 4'd0, 32'hD0, 32'h300, 32'd49);
    chk("to_frozen", cycle_cnt, 49);
    #2;
    reset = 1'b0;
    #1;
    chk_rec("arst", 0, 2'd0, 4'd0, 32'h0, 32'h0, 32'h0);
    chk("arst_cycle", cycle_cnt, 0);
    chk_flags("arst_flags", 0, 0, 0, 0);

    // Randomized sessions against the reference model.
    for (int s = 0; s < 12; s++) begin
      do_reset();
      model_reset();
      for (int c = 0; c < 60; c++) begin
        state      = ($urandom_range(2) == 0) ? FETCH : 4'($urandom_range(9, 1));
        PC         = 32'h40 + 32'($urandom_range(2) * 4);
        RegWrite   = ($urandom_range(2) == 0);
        MemWrite   = ($urandom_range(3) == 0);
        IsLongMul  = !MemWrite && ($urandom_range(1) == 0);
        Rd         = 4'($urandom);
        Ra         = 4'($urandom);
        Result     = $urandom;
        ALUResult2 = $urandom;
        Adr        = $urandom;
        WriteData  = $urandom;
        tr_ready   = ($urandom_range(3) < (s % 4));
        model_step();
        tick();
        if (q.size() > 0) er = q[0]; else er = '{2'd0, 4'd0, 32'd0, 32'd0, 32'd0};
        chk_rec($sformatf("rnd%0d_%0d", s, c), q.size() > 0, er.kind, er.idx, er.data, er.addr, er.cyc);
        chk($sformatf("rnd%0d_%0d_cycle", s, c), cycle_cnt, 32'(m_cyc));
        chk($sformatf("rnd%0d_%0d_instr", s, c), instr_cnt, 32'(m_instr));
        chk_flags($sformatf("rnd%0d_%0d_flags", s, c), m_done, m_halted, m_timeout, m_ovf);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
